// File: rtl/alu_result_display.sv
// Converts a captured ALU result to sign plus three BCD digits by double-dabble
// and scans them onto a 4-digit multiplexed, active-low seven-segment display.
module alu_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  input  logic       is_signed,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [1:0]    state;
  logic [2:0]    bitcnt;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [7:0]    mag;
  logic          neg;
  logic [7:0]    load_mag;
  logic          load_neg;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic          disp_neg;
  logic [CW-1:0] refresh;
  logic [1:0]    scan_idx;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  // Magnitude of the incoming result; 8'h80 signed maps to 128, which still fits 8 bits.
  always_comb begin
    load_neg = is_signed & result[7];
    load_mag = load_neg ? (~result + 8'd1) : result;
  end

  always_comb begin
    bcd_adj[3:0]  = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
    bcd_adj[7:4]  = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
    bcd_adj[11:8] = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];
  end

  assign busy = (state != IDLE);

  // Conversion FSM; display registers only change on the COMMIT edge so digits update atomically.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      bcd      <= 12'd0;
      mag      <= 8'd0;
      neg      <= 1'b0;
      done     <= 1'b0;
      hund     <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      disp_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            mag    <= load_mag;
            neg    <= load_neg;
            bcd    <= 12'd0;
            bitcnt <= 3'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
          bitcnt     <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          hund     <= bcd[11:8];
          tens     <= bcd[7:4];
          ones     <= bcd[3:0];
          disp_neg <= neg;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh  <= '0;
      scan_idx <= 2'd0;
    end else if (refresh == REFRESH_MAX) begin
      refresh  <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  assign an = ~(4'b0001 << scan_idx);

  always_comb begin
    seg = SEG_BLANK;
    case (scan_idx)
      2'd0: seg = decode(ones);
      2'd1: seg = (BLANK_LZ && hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : decode(tens);
      2'd2: seg = (BLANK_LZ && hund == 4'd0) ? SEG_BLANK : decode(hund);
      2'd3: seg = disp_neg ? SEG_DASH : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
